// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the MULT interface issue controller.
package mult_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_MULH = 3'b001;
  localparam int TIMEOUT_CYC_DEF = 64;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH);
  endfunction
endpackage

// File: rtl/mult_watchdog.sv
// Saturating cycle counter; expired marks the TIMEOUT_CYC-th consecutive enabled cycle.
module mult_watchdog
  import mult_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/mult_issue_ctrl.sv
// Execute-stage issue controller for the radix-8 multiplier (MULT interface initiator).
// Optional one-entry result cache enabled by defining MULT_RESULT_CACHE_EN.
module mult_issue_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int LENGTH      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [LENGTH-1:0] REQ_A,
  input  logic [LENGTH-1:0] REQ_B,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [4:0]        REQ_RD,
  output logic [LENGTH-1:0] OPER_A,
  output logic [LENGTH-1:0] OPER_B,
  output logic              ENABLE_MULT,
  output logic              FUCT3,
  input  logic [LENGTH-1:0] MULT_O,
  input  logic              MULT_FINISH,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [LENGTH-1:0] RSP_DATA,
  output logic [4:0]        RSP_RD,
  output logic              RSP_ERR,
  output logic              STALL,
  output logic [1:0]        DBG_STATE
);
  // Handshakes: a request transfers on a rising edge with REQ_VALID && REQ_READY;
  // a response transfers on a rising edge with RSP_VALID && RSP_READY. Each side
  // holds its payload stable while valid is high and not yet accepted.
  state_e            state_q, state_d;
  logic [LENGTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic              f3_q, f3_d, err_q, err_d;
  logic [4:0]        rd_q, rd_d;
  logic              wd_expired;
  logic              cache_hit;

  mult_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (state_q != BUSY),
    .en     (state_q == BUSY),
    .expired(wd_expired)
  );

`ifdef MULT_RESULT_CACHE_EN
  logic              c_valid_q, c_valid_d, c_f3_q, c_f3_d;
  logic [LENGTH-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_res_q, c_res_d;

  assign cache_hit = c_valid_q && (c_a_q == REQ_A) && (c_b_q == REQ_B) &&
                     (c_f3_q == REQ_FUNCT3[0]);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef MULT_RESULT_CACHE_EN
    c_valid_d = c_valid_q;
    c_f3_d    = c_f3_q;
    c_a_d     = c_a_q;
    c_b_d     = c_b_q;
    c_res_d   = c_res_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          rd_d = REQ_RD;
          if (f3_legal(REQ_FUNCT3)) begin
            a_d  = REQ_A;
            b_d  = REQ_B;
            f3_d = REQ_FUNCT3[0];
            if (cache_hit) begin
              state_d = RESP;
              err_d   = 1'b0;
`ifdef MULT_RESULT_CACHE_EN
              data_d  = c_res_q;
`endif
            end else begin
              state_d = BUSY;
            end
          end else begin
            state_d = RESP;
            data_d  = '0;
            err_d   = 1'b1;
`ifdef MULT_RESULT_CACHE_EN
            c_valid_d = 1'b0;
`endif
          end
        end
      end
      BUSY: begin
        // A finish in the same cycle as expiry still delivers the real result.
        if (MULT_FINISH) begin
          state_d = RESP;
          data_d  = MULT_O;
          err_d   = 1'b0;
`ifdef MULT_RESULT_CACHE_EN
          c_valid_d = 1'b1;
          c_a_d     = a_q;
          c_b_d     = b_q;
          c_f3_d    = f3_q;
          c_res_d   = MULT_O;
`endif
        end else if (wd_expired) begin
          state_d = RESP;
          data_d  = '0;
          err_d   = 1'b1;
`ifdef MULT_RESULT_CACHE_EN
          c_valid_d = 1'b0;
`endif
        end
      end
      RESP: begin
        if (RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MULT_RESULT_CACHE_EN
      c_valid_q <= 1'b0;
      c_f3_q    <= 1'b0;
      c_a_q     <= '0;
      c_b_q     <= '0;
      c_res_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MULT_RESULT_CACHE_EN
      c_valid_q <= c_valid_d;
      c_f3_q    <= c_f3_d;
      c_a_q     <= c_a_d;
      c_b_q     <= c_b_d;
      c_res_q   <= c_res_d;
`endif
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign REQ_READY   = (state_q == IDLE);
  assign ENABLE_MULT = (state_q == BUSY);
  assign RSP_VALID   = (state_q == RESP);
  assign STALL       = (state_q != IDLE);
  assign OPER_A      = a_q;
  assign OPER_B      = b_q;
  assign FUCT3       = f3_q;
  assign RSP_DATA    = data_q;
  assign RSP_RD      = rd_q;
  assign RSP_ERR     = err_q;
  assign DBG_STATE   = state_q;
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl; emulates the multiplier and models RV32M products.
module tb_mult_issue_ctrl;
  import mult_ctrl_pkg::*;

  localparam int TO = 16;

  logic        CLK, RST_N;
  logic        REQ_VALID, REQ_READY;
  logic [31:0] REQ_A, REQ_B;
  logic [2:0]  REQ_FUNCT3;
  logic [4:0]  REQ_RD;
  logic [31:0] OPER_A, OPER_B;
  logic        ENABLE_MULT, FUCT3;
  logic [31:0] MULT_O;
  logic        MULT_FINISH;
  logic        RSP_VALID, RSP_READY;
  logic [31:0] RSP_DATA;
  logic [4:0]  RSP_RD;
  logic        RSP_ERR, STALL;
  logic [1:0]  DBG_STATE;

  int total = 0;
  int bad   = 0;

  logic        c_valid = 1'b0;
  logic [31:0] c_a, c_b;
  logic        c_f3;

  mult_issue_ctrl #(.LENGTH(32), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUNCT3(REQ_FUNCT3), .REQ_RD(REQ_RD),
    .OPER_A(OPER_A), .OPER_B(OPER_B), .ENABLE_MULT(ENABLE_MULT), .FUCT3(FUCT3),
    .MULT_O(MULT_O), .MULT_FINISH(MULT_FINISH),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_DATA(RSP_DATA), .RSP_RD(RSP_RD), .RSP_ERR(RSP_ERR),
    .STALL(STALL), .DBG_STATE(DBG_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mult(input logic [31:0] a, input logic [31:0] b,
                                             input logic hi);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return hi ? p[63:32] : p[31:0];
  endfunction

  // k = cycle of BUSY on which the multiplier finishes; 0 = never finishes.
  task automatic transact(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          input logic [4:0] rd, input int k, input int hold);
    logic        legal, hit, done, exp_err;
    logic [31:0] exp_data;
    int          en_cnt;
    legal    = (f3 == F3_MUL) || (f3 == F3_MULH);
    exp_data = model_mult(a, b, f3[0]);
    hit      = 1'b0;
`ifdef MULT_RESULT_CACHE_EN
    hit = legal && c_valid && (c_a == a) && (c_b == b) && (c_f3 == f3[0]);
`endif
    @(negedge CLK);
    chk("req_ready_idle", REQ_READY, 1);
    REQ_VALID = 1'b1; REQ_A = a; REQ_B = b; REQ_FUNCT3 = f3; REQ_RD = rd;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_A = $urandom; REQ_B = $urandom;
    REQ_FUNCT3 = 3'($urandom_range(0, 7)); REQ_RD = 5'($urandom_range(0, 31));
    en_cnt = 0;
    done   = 1'b0;
    exp_err = !legal;
    if (legal && !hit) begin
      for (int i = 1; i <= TO && !done; i++) begin
        @(negedge CLK);
        chk("busy_enable", ENABLE_MULT, 1);
        chk("busy_oper_a", OPER_A, a);
        chk("busy_oper_b", OPER_B, b);
        chk("busy_fuct3", FUCT3, f3[0]);
        chk("busy_stall", STALL, 1);
        chk("busy_req_ready", REQ_READY, 0);
        chk("busy_rsp_valid", RSP_VALID, 0);
        en_cnt++;
        if (i == k) begin
          MULT_FINISH = 1'b1; MULT_O = exp_data;
        end
        @(posedge CLK); #1;
        MULT_FINISH = 1'b0; MULT_O = $urandom;
        if (i == k) done = 1'b1;
      end
      exp_err = !done;
      chk("enable_cycles", en_cnt, (k == 0) ? TO : k);
    end
    if (exp_err) exp_data = '0;
    if (exp_err) c_valid = 1'b0;
    else if (legal) begin
      c_valid = 1'b1; c_a = a; c_b = b; c_f3 = f3[0];
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge CLK);
      chk("rsp_valid", RSP_VALID, 1);
      chk("rsp_data", RSP_DATA, exp_data);
      chk("rsp_rd", RSP_RD, rd);
      chk("rsp_err", RSP_ERR, exp_err);
      chk("rsp_enable_low", ENABLE_MULT, 0);
      chk("rsp_stall", STALL, 1);
      chk("rsp_req_ready", REQ_READY, 0);
      if (h == hold) RSP_READY = 1'b1;
      else begin
        MULT_FINISH = 1'b1; MULT_O = $urandom;
      end
      @(posedge CLK); #1;
      RSP_READY = 1'b0; MULT_FINISH = 1'b0;
    end
    @(negedge CLK);
    chk("post_rsp_valid", RSP_VALID, 0);
    chk("post_req_ready", REQ_READY, 1);
    chk("post_stall", STALL, 0);
  endtask

  initial begin
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_A = '0; REQ_B = '0; REQ_FUNCT3 = '0; REQ_RD = '0;
    MULT_O = '0; MULT_FINISH = 1'b0; RSP_READY = 1'b0;
    #12;
    chk("rst_req_ready", REQ_READY, 1);
    chk("rst_enable", ENABLE_MULT, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_stall", STALL, 0);
    chk("rst_rsp_data", RSP_DATA, 0);
    chk("rst_oper_a", OPER_A, 0);
    chk("rst_state", DBG_STATE, 32'(IDLE));
    @(negedge CLK); RST_N = 1'b1;

    transact(32'd7, 32'hFFFF_FFFD, 3'b000, 5'd5, 3, 0);
    transact(32'h8000_0000, 32'd2, 3'b001, 5'd9, 2, 5);
    transact(32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 5'd12, 1, 1);
    transact(32'd100, 32'd200, 3'b000, 5'd3, 0, 0);
    transact(32'hDEAD_BEEF, 32'h0000_0010, 3'b001, 5'd17, TO, 1);
    transact(32'd5, 32'd6, 3'b100, 5'd31, 1, 0);
    transact(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 5'd1, 1, 2);

    for (int n = 0; n < 14; n++) begin
      logic [2:0] f;
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      transact($urandom, $urandom, f, 5'($urandom_range(0, 31)),
               $urandom_range(1, 6), $urandom_range(0, 3));
    end

    // Reset in the middle of a BUSY multiply.
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_A = 32'd7; REQ_B = 32'hFFFF_FFFD; REQ_FUNCT3 = 3'b000; REQ_RD = 5'd5;
    @(posedge CLK); #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("mid_enable_before", ENABLE_MULT, 1);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_enable", ENABLE_MULT, 0);
    chk("mid_rst_rsp_valid", RSP_VALID, 0);
    chk("mid_rst_req_ready", REQ_READY, 1);
    MULT_FINISH = 1'b1; MULT_O = 32'hFFFF_FFEB;
    c_valid = 1'b0;
    @(negedge CLK);
    MULT_FINISH = 1'b0; RST_N = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      chk("after_rst_no_rsp", RSP_VALID, 0);
      chk("after_rst_enable", ENABLE_MULT, 0);
    end

    transact(32'd7, 32'hFFFF_FFFD, 3'b000, 5'd5, 3, 0);
    transact(32'd7, 32'hFFFF_FFFD, 3'b000, 5'd6, 3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
